// File: rtl/scratchpad_arbiter_pkg.sv
// Shared types and the round-robin search used by both arbitration classes.
package scratchpad_arbiter_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of cand at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] cand,
                                         input int unsigned        ptr,
                                         input int unsigned        n);
        rr_pick_t         r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !r.found) begin
                j = IDX_W'((ptr + k) % n);
                if (cand[j]) begin
                    r.found = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scratchpad_arbiter_if.sv
// Requester-side bus of the scratchpad arbiter: packed per-requester lanes.
interface scratchpad_arbiter_if #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned ADDR_BITWIDTH = 10,
    parameter int unsigned NUM_REQ       = 4
);
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               we;
    logic [NUM_REQ*ADDR_BITWIDTH-1:0] addr;
    logic [NUM_REQ*DATA_BITWIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]               gnt;
    logic [NUM_REQ-1:0]               rvalid;
    logic [DATA_BITWIDTH-1:0]         rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/scratchpad_arbiter_scratchpad.sv
// Single-port-write / single-port-read SRAM with registered read data.
module scratchpad_arbiter_scratchpad #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned ADDR_BITWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [ADDR_BITWIDTH-1:0] i_waddr,
    input  logic [DATA_BITWIDTH-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [ADDR_BITWIDTH-1:0] i_raddr,
    output logic [DATA_BITWIDTH-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] r_mem [DEPTH];

    // Array is intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Same-edge read of a written address returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/scratchpad_arbiter.sv
// Independent round-robin read and write arbitration of NUM_REQ requesters
// onto one shared scratchpad.
module scratchpad_arbiter
    import scratchpad_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned ADDR_BITWIDTH = 10,
    parameter int unsigned NUM_REQ       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    scratchpad_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [NUM_REQ-1:0]       r_rvalid;

    rr_pick_t                 w_rd_pick;
    rr_pick_t                 w_wr_pick;
    logic                     w_re;
    logic                     w_we;
    logic [NUM_REQ-1:0]       w_rd_gnt;
    logic [NUM_REQ-1:0]       w_wr_gnt;
    logic [ADDR_BITWIDTH-1:0] w_raddr;
    logic [ADDR_BITWIDTH-1:0] w_waddr;
    logic [DATA_BITWIDTH-1:0] w_wdata;

    // Winner selection per class and steering of the winning lane.
    always_comb begin
        w_rd_pick = rr_pick(MAX_REQ'(bus.req & ~bus.we), 32'(r_rd_ptr), NUM_REQ);
        w_wr_pick = rr_pick(MAX_REQ'(bus.req & bus.we), 32'(r_wr_ptr), NUM_REQ);
        w_re      = w_rd_pick.found & ~reset;
        w_we      = w_wr_pick.found & ~reset;
        w_rd_gnt  = '0;
        w_wr_gnt  = '0;
        w_raddr   = '0;
        w_waddr   = '0;
        w_wdata   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rd_pick.idx == IDX_W'(i)) begin
                w_rd_gnt[i] = w_re;
                w_raddr     = bus.addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
            end
            if (w_wr_pick.idx == IDX_W'(i)) begin
                w_wr_gnt[i] = w_we;
                w_waddr     = bus.addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
                w_wdata     = bus.wdata[i*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

    assign bus.gnt    = w_rd_gnt | w_wr_gnt;
    assign bus.rvalid = r_rvalid;

    // Pointers advance past the winner; read response flag trails grant by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rd_gnt;
            if (w_re) begin
                r_rd_ptr <= PTR_W'((32'(w_rd_pick.idx) + 32'd1) % NUM_REQ);
            end
            if (w_we) begin
                r_wr_ptr <= PTR_W'((32'(w_wr_pick.idx) + 32'd1) % NUM_REQ);
            end
        end
    end

    scratchpad_arbiter_scratchpad #(
        .DATA_BITWIDTH(DATA_BITWIDTH),
        .ADDR_BITWIDTH(ADDR_BITWIDTH)
    ) scratchpad (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (bus.rdata)
    );

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed vector bench for scratchpad_arbiter (4 requesters, 8-bit data).
module tb_scratchpad_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [39:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [7:0]  rd;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    scratchpad_arbiter_if #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(10), .NUM_REQ(4)) bus ();

    scratchpad_arbiter #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(10), .NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] we,
                                logic [39:0] addr, logic [31:0] wdata,
                                logic [3:0] gnt, logic [3:0] rv, logic [7:0] rd);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    function automatic logic [39:0] al(int lane, logic [9:0] a);
        logic [39:0] r;
        r = 40'(a);
        return r << (lane * 10);
    endfunction

    function automatic logic [31:0] dl(int lane, logic [7:0] d);
        logic [31:0] r;
        r = 32'(d);
        return r << (lane * 8);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    localparam logic [39:0] A_SEQ = {10'h23, 10'h22, 10'h21, 10'h20};
    localparam logic [39:0] A_30  = {10'h30, 10'h30, 10'h30, 10'h30};
    localparam logic [39:0] A_31  = {10'h31, 10'h31, 10'h31, 10'h31};
    localparam logic [31:0] D_B   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    localparam logic [31:0] D_C   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};

    initial begin
        logic [3:0] g;
        logic [3:0] exp_g;
        int         cnt [4];
        n_checks = 0;
        n_fail   = 0;

        vecs.push_back(mk(1, 4'hF, 4'h0, A_SEQ, 0, 4'h0, 4'h0, 8'h00));
        // Preload 0x20..0x23, writers served in round-robin order.
        vecs.push_back(mk(0, 4'hF, 4'hF, A_SEQ, D_B, 4'h1, 4'h0, 8'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, A_SEQ, D_B, 4'h2, 4'h0, 8'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, A_SEQ, D_B, 4'h4, 4'h0, 8'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, A_SEQ, D_B, 4'h8, 4'h0, 8'h00));
        vecs.push_back(mk(1, 4'hF, 4'h0, A_SEQ, 0, 4'h0, 4'h0, 8'h00));
        // All reading: 0001,0010,0100,1000,0001; contents survive reset.
        vecs.push_back(mk(0, 4'hF, 4'h0, A_SEQ, 0, 4'h1, 4'h1, 8'hB0));
        vecs.push_back(mk(0, 4'hF, 4'h0, A_SEQ, 0, 4'h2, 4'h2, 8'hB1));
        vecs.push_back(mk(0, 4'hF, 4'h0, A_SEQ, 0, 4'h4, 4'h4, 8'hB2));
        vecs.push_back(mk(0, 4'hF, 4'h0, A_SEQ, 0, 4'h8, 4'h8, 8'hB3));
        vecs.push_back(mk(0, 4'hF, 4'h0, A_SEQ, 0, 4'h1, 4'h1, 8'hB0));
        // we=0101: reads alternate 1,3 and writes alternate 0,2.
        vecs.push_back(mk(0, 4'hF, 4'h5, A_SEQ, D_C, 4'h3, 4'h2, 8'hB1));
        vecs.push_back(mk(0, 4'hF, 4'h5, A_SEQ, D_C, 4'hC, 4'h8, 8'hB3));
        vecs.push_back(mk(0, 4'hF, 4'h5, A_SEQ, D_C, 4'h3, 4'h2, 8'hB1));
        vecs.push_back(mk(0, 4'hF, 4'h5, A_SEQ, D_C, 4'hC, 4'h8, 8'hB3));
        vecs.push_back(mk(0, 4'h4, 4'h0, A_SEQ, 0, 4'h4, 4'h4, 8'hC2));
        // Write 0xA5 at 0x05 by requester 2, then requester 0 reads it.
        vecs.push_back(mk(0, 4'h4, 4'h4, al(2, 10'h05), dl(2, 8'hA5), 4'h4, 4'h0, 8'hC2));
        vecs.push_back(mk(0, 4'h1, 4'h0, al(0, 10'h05), 0, 4'h1, 4'h1, 8'hA5));
        // Same-address read/write collision returns the old word.
        vecs.push_back(mk(0, 4'h2, 4'h2, al(1, 10'h10), dl(1, 8'h11), 4'h2, 4'h0, 8'hA5));
        vecs.push_back(mk(0, 4'hA, 4'h2, al(1, 10'h10) | al(3, 10'h10), dl(1, 8'h3C),
                          4'hA, 4'h8, 8'h11));
        vecs.push_back(mk(0, 4'h8, 4'h0, al(3, 10'h10), 0, 4'h8, 4'h8, 8'h3C));
        vecs.push_back(mk(0, 4'h8, 4'h0, al(3, 10'h10), 0, 4'h8, 4'h8, 8'h3C));
        // Read 0x7E from 0x30, then idle ten cycles.
        vecs.push_back(mk(0, 4'h1, 4'h1, al(0, 10'h30), dl(0, 8'h7E), 4'h1, 4'h0, 8'h3C));
        vecs.push_back(mk(0, 4'h1, 4'h0, al(0, 10'h30), 0, 4'h1, 4'h1, 8'h7E));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 8'h7E));
        // Pointers held across idle: rd_ptr=1, wr_ptr=1.
        vecs.push_back(mk(0, 4'hF, 4'h0, A_30, 0, 4'h2, 4'h2, 8'h7E));
        vecs.push_back(mk(0, 4'hF, 4'hF, A_31, {4{8'h55}}, 4'h2, 4'h0, 8'h7E));
        // Read grant followed by reset cancels response and clears rd_ptr.
        vecs.push_back(mk(0, 4'h1, 4'h0, A_30, 0, 4'h1, 4'h1, 8'h7E));
        vecs.push_back(mk(1, 4'h1, 4'h0, A_30, 0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(0, 4'hF, 4'h0, A_30, 0, 4'h1, 4'h1, 8'h7E));
        vecs.push_back(mk(0, 4'h2, 4'h0, al(1, 10'h31), 0, 4'h2, 4'h2, 8'h55));

        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            bus.req   = vecs[i].req;
            bus.we    = vecs[i].we;
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            #1;
            check("gnt", i, 32'(bus.gnt), 32'(vecs[i].gnt));
            @(negedge clk);
            check("rvalid", i, 32'(bus.rvalid), 32'(vecs[i].rv));
            check("rdata", i, 32'(bus.rdata), 32'(vecs[i].rd));
        end

        // Fairness: all four reading continuously from rd_ptr=2.
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        bus.req  = 4'hF;
        bus.we   = 4'h0;
        bus.addr = A_30;
        for (int c = 0; c < 8; c++) begin
            #1;
            g     = bus.gnt;
            exp_g = 4'b0001 << ((2 + c) % 4);
            check("fair_gnt", c, 32'(g), 32'(exp_g));
            for (int r = 0; r < 4; r++) if (g[r]) cnt[r]++;
            @(negedge clk);
            check("fair_rvalid", c, 32'(bus.rvalid), 32'(exp_g));
            check("fair_rdata", c, 32'(bus.rdata), 32'h7E);
        end
        for (int r = 0; r < 4; r++) check("fair_count", r, 32'(cnt[r]), 32'd2);

        bus.req = 4'h0;
        #1;
        check("idle_gnt", 0, 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check("idle_rvalid", 0, 32'(bus.rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scratchpad_arbiter.md
SCRATCHPAD_ARBITER -- requirements
Module: scratchpad_arbiter

Interface
REQ-001 Parameter DATA_BITWIDTH, default 8, word width of the shared scratchpad.
REQ-002 Parameter ADDR_BITWIDTH, default 10, scratchpad address width (depth 2^ADDR_BITWIDTH).
REQ-003 Parameter NUM_REQ, default 4, number of requesters, legal range 2..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester access request, level-held until granted.
REQ-007 we  input  NUM_REQ  per-requester op select: 1 = write, 0 = read; valid with req.
REQ-008 addr  input  NUM_REQ*ADDR_BITWIDTH  packed per-requester addresses; requester i at slice i.
REQ-009 wdata  input  NUM_REQ*DATA_BITWIDTH  packed per-requester write data; requester i at slice i.
REQ-010 gnt  output  NUM_REQ  one-hot-or-zero per port class; request accepted this cycle.
REQ-011 rvalid  output  NUM_REQ  read data for requester i valid on rdata this cycle.
REQ-012 rdata  output  DATA_BITWIDTH  shared read data bus, broadcast to all requesters.

Function
REQ-013 Read and write are arbitrated independently; at most one read grant and one write grant per cycle.
REQ-014 Read candidates: req[i] & ~we[i]; write candidates: req[i] & we[i].
REQ-015 Each class uses round-robin: search starts at its pointer (rd_ptr / wr_ptr), first candidate at or after pointer, wrapping modulo NUM_REQ, wins.
REQ-016 Grant is combinational in the request cycle; gnt[i] high only if requester i wins its class.
REQ-017 On a grant in a class, that class pointer becomes (winner + 1) mod NUM_REQ at the next edge; no grant -> pointer unchanged.
REQ-018 Granted write: memory[addr_i] <= wdata_i at the grant edge.
REQ-019 Granted read: memory[addr_i] sampled at grant edge; rvalid[i] = 1 and rdata valid exactly one cycle after gnt[i].
REQ-020 rvalid is one-hot-or-zero; rvalid is 0 in any cycle following a cycle without a read grant.
REQ-021 rdata holds its last value when no read is granted.
REQ-022 Simultaneous read and write grant to the same address: read returns the pre-write (old) data; the write still completes.
REQ-023 A requester whose req is high and not granted keeps req, we, addr, wdata stable; arbiter does not queue requests.
REQ-024 Back-to-back grants to the same requester are permitted when it is the sole candidate of its class.
REQ-025 Fairness bound: with all NUM_REQ requesters continuously requesting one class, each is granted once every NUM_REQ cycles.

Reset
REQ-026 While reset is high: gnt = 0, no memory write or read is issued.
REQ-027 At the reset edge: rd_ptr = 0, wr_ptr = 0, rvalid = 0, rdata = 0.
REQ-028 Reset asserted the cycle after a read grant cancels that response: rvalid = 0, rdata = 0 next cycle.
REQ-029 Memory contents are not cleared by reset.

Structure
REQ-030 The scratchpad SRAM is instantiated as the single sub-module scratchpad, driven by the arbiter's winning read/write address, data and enables.
REQ-031 Round-robin search is one shared function or generate structure reused for both classes.
REQ-032 No package required; pointer width is clog2(NUM_REQ) as a local constant.

Verification
REQ-033 Reset, then req=4'b1111, we=0, all idle otherwise -> gnt sequence 0001,0010,0100,1000,0001; rvalid follows gnt by one cycle.
REQ-034 Requester 2 writes addr 0x05 data 0xA5, next cycle requester 0 reads 0x05 -> gnt[0] that cycle, rvalid[0]=1 and rdata=0xA5 one cycle later.
REQ-035 Same cycle: requester 1 writes 0x3C to addr 0x10 (old 0x11), requester 3 reads 0x10 -> both granted; rdata=0x11; following read returns 0x3C.
REQ-036 req=4'b1111, we=4'b0101 -> read and write grant each cycle: reads alternate 1,3; writes alternate 0,2.
REQ-037 Read granted at cycle N, reset high at N+1 -> rvalid=0, rdata=0 at N+1 edge; after reset release, rd_ptr=0 (requester 0 wins first).
REQ-038 No requests for 10 cycles after a read of 0x7E -> rvalid=0, rdata stays 0x7E, pointers unchanged.
